// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared FSM state type, frame constants and a parity helper for the
//   uart_port slice (uart_port top and uart_rx_sampler).
//   The optional parity bit is enabled with the macro UART_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Receive half of uart_port: synchronizes rxd, detects the start bit,
//   samples each bit in the middle of its bit time (LSB first) and loads the
//   receive buffer register (RBR) when a frame ends with a valid stop bit.
//   With UART_PARITY_EN defined an even-parity bit is expected between the
//   data and stop bits, and a parity mismatch discards the byte.
//
// Ports
//   CLK        block clock
//   RST        asynchronous reset, active low
//   rxd        serial input, asynchronous to CLK
//   rd_clear   one-cycle pulse: the host finished reading RBR
//   rbr        receive buffer register
//   data_ready RBR holds an unread byte
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
)
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rxd,
    input  logic                      rd_clear,
    output logic [UART_DATA_BITS-1:0] rbr,
    output logic                      data_ready
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic rxd_meta;
    logic rxd_sync;
    logic rxd_prev;

    uart_state_t state;
    uart_state_t state_next;

    logic [CNT_W-1:0]          bit_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;

    logic start_seen;
    logic half_point;
    logic bit_end;
    logic sample_data;
    logic frame_ok;
    logic load_rbr;

`ifdef UART_PARITY_EN
    logic parity_bit;
    logic sample_parity;
`endif

    // The synchronizer idles at the line idle level so reset never looks
    // like a start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rxd_meta <= UART_IDLE_LEVEL;
            rxd_sync <= UART_IDLE_LEVEL;
            rxd_prev <= UART_IDLE_LEVEL;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign start_seen = rxd_prev & ~rxd_sync;
    assign half_point = (bit_cnt == HALF_CNT);
    assign bit_end    = (bit_cnt == LAST_CNT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // After the mid-start re-check the counter restarts, so every later
    // bit_end lands in the middle of a bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_seen) state_next = START;
            START:   if (half_point) state_next = rxd_sync ? IDLE : DATA;
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sample_data = (state == DATA) && bit_end;
        frame_ok    = (rxd_sync == UART_IDLE_LEVEL);
`ifdef UART_PARITY_EN
        sample_parity = (state == PARITY) && bit_end;
        frame_ok      = frame_ok && (even_parity(shift) == parity_bit);
`endif
        load_rbr    = (state == STOP) && bit_end && frame_ok;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (state == IDLE || state_next != state || bit_end) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (sample_data) begin
                shift <= {rxd_sync, shift[UART_DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            parity_bit <= 1'b0;
        end else if (sample_parity) begin
            parity_bit <= rxd_sync;
        end
    end
`endif

    // A load in the same cycle as a read completion wins, so the new byte
    // is never reported as already read.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rbr        <= '0;
            data_ready <= 1'b0;
        end else if (load_rbr) begin
            rbr        <= shift;
            data_ready <= 1'b1;
        end else if (rd_clear) begin
            data_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_port.sv
// uart_port
//   UART responder on the CPU serial bus. Holds a transmit holding register
//   (THR) and transmit shift register (TSR), and a receive buffer (RBR) in
//   uart_rx_sampler. Bus strobes are asynchronous and are synchronized
//   before their rising edges are used.
//   Optional even parity: define UART_PARITY_EN (8E1 instead of 8N1).
//
// Ports
//   CLK        block clock
//   RST        asynchronous reset, active low
//   rdn        read strobe, active low, asynchronous
//   wrn        write strobe, active low, asynchronous
//   data       shared bus, driven with RBR while rdn is low
//   data_ready RBR holds an unread byte
//   tbre       THR empty
//   tsre       TSR empty, line idle
//   txd        serial output, idle high
//   rxd        serial input, asynchronous
module uart_port
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
)
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rdn,
    input  logic                      wrn,
    inout  wire  [UART_DATA_BITS-1:0] data,
    output logic                      data_ready,
    output logic                      tbre,
    output logic                      tsre,
    output logic                      txd,
    input  logic                      rxd
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic rdn_meta, rdn_sync, rdn_prev;
    logic wrn_meta, wrn_sync, wrn_prev;
    logic rd_rise;
    logic wr_rise;

    logic [UART_DATA_BITS-1:0] staging;
    logic [UART_DATA_BITS-1:0] thr;
    logic [UART_DATA_BITS-1:0] tsr;
    logic [UART_DATA_BITS-1:0] rbr;

    uart_state_t tx_state;
    uart_state_t tx_next;

    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic             tx_bit_end;
    logic             load_tsr;
    logic             frame_done;

    // Output enable follows the raw strobe so the bus is released as soon
    // as the controller lets go of rdn.
    assign data = rdn ? {UART_DATA_BITS{1'bz}} : rbr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdn_meta <= 1'b1;
            rdn_sync <= 1'b1;
            rdn_prev <= 1'b1;
            wrn_meta <= 1'b1;
            wrn_sync <= 1'b1;
            wrn_prev <= 1'b1;
        end else begin
            rdn_meta <= rdn;
            rdn_sync <= rdn_meta;
            rdn_prev <= rdn_sync;
            wrn_meta <= wrn;
            wrn_sync <= wrn_meta;
            wrn_prev <= wrn_sync;
        end
    end

    assign rd_rise    = rdn_sync & ~rdn_prev;
    assign wr_rise    = wrn_sync & ~wrn_prev;
    assign tx_bit_end = (tx_cnt == LAST_CNT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_state <= IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // STOP goes straight to START when THR is already full, giving
    // back-to-back frames with no idle gap.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:    if (!tbre) tx_next = START;
            START:   if (tx_bit_end) tx_next = DATA;
            DATA: begin
                if (tx_bit_end && tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                    tx_next = PARITY;
`else
                    tx_next = STOP;
`endif
                end
            end
            PARITY:  if (tx_bit_end) tx_next = STOP;
            STOP:    if (tx_bit_end) tx_next = tbre ? IDLE : START;
            default: tx_next = IDLE;
        endcase
    end

    // txd is decoded from the state so the asynchronous reset drives the
    // line idle immediately.
    always_comb begin
        txd        = UART_IDLE_LEVEL;
        load_tsr   = 1'b0;
        frame_done = 1'b0;
        case (tx_state)
            IDLE:   load_tsr = !tbre;
            START:  txd = ~UART_IDLE_LEVEL;
            DATA:   txd = tsr[tx_idx];
            PARITY: txd = even_parity(tsr);
            STOP: begin
                load_tsr   = tx_bit_end && !tbre;
                frame_done = tx_bit_end && tbre;
            end
            default: txd = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_cnt <= '0;
            tx_idx <= '0;
        end else begin
            if (tx_state == IDLE || tx_bit_end) begin
                tx_cnt <= '0;
            end else begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end

            if (tx_state != DATA) begin
                tx_idx <= '0;
            end else if (tx_bit_end) begin
                tx_idx <= tx_idx + 3'd1;
            end
        end
    end

    // The commit is evaluated after the transfer so that, should both
    // happen together, TSR takes the old THR and tbre ends low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            staging <= '0;
            thr     <= '0;
            tsr     <= '0;
            tbre    <= 1'b1;
            tsre    <= 1'b1;
        end else begin
            if (!wrn_sync) begin
                staging <= data;
            end

            if (load_tsr) begin
                tsr  <= thr;
                tbre <= 1'b1;
                tsre <= 1'b0;
            end else if (frame_done) begin
                tsre <= 1'b1;
            end

            if (wr_rise && tbre) begin
                thr  <= staging;
                tbre <= 1'b0;
            end
        end
    end

    uart_rx_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .CLK        (CLK),
        .RST        (RST),
        .rxd        (rxd),
        .rd_clear   (rd_rise),
        .rbr        (rbr),
        .data_ready (data_ready)
    );

endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port
//   Scoreboard bench for uart_port with CLKS_PER_BIT = 4 (8N1 build).
//   Writes push the byte expected on txd; reads push the byte expected on
//   data. Independent monitors decode txd frames and sample the bus during
//   reads, popping and comparing against those queues.
module tb_uart_port;

    localparam int CPB = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rdn = 1'b1;
    logic       wrn = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] bus_drv = 8'h00;
    logic       bus_en = 1'b0;
    wire  [7:0] data;
    logic       data_ready;
    logic       tbre;
    logic       tsre;
    logic       txd;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rd_exp[$];

    assign data = bus_en ? bus_drv : 8'bz;

    uart_port #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .rdn        (rdn),
        .wrn        (wrn),
        .data       (data),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .txd        (txd),
        .rxd        (rxd)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic doWrite(input logic [7:0] value, input bit accept);
        if (accept) tx_exp.push_back(value);
        @(posedge CLK); #1;
        bus_drv = value;
        bus_en  = 1'b1;
        wrn     = 1'b0;
        repeat (4) @(posedge CLK);
        #1 wrn = 1'b1;
        repeat (4) @(posedge CLK);
        #1 bus_en = 1'b0;
    endtask

    task automatic doRead(input logic [7:0] expected);
        rd_exp.push_back(expected);
        @(posedge CLK);
        #1 rdn = 1'b0;
        repeat (4) @(posedge CLK);
        #1 rdn = 1'b1;
    endtask

    task automatic sendRxFrame(input logic [7:0] value, input logic stop_level);
        logic [9:0] frame;
        frame = {stop_level, value, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1 rxd = frame[i];
            repeat (CPB - 1) @(posedge CLK);
        end
        @(posedge CLK);
        #1 rxd = 1'b1;
        repeat (2 * CPB) @(posedge CLK);
    endtask

    task automatic applyStimulus();
        int n;

        // Reset state
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        checkOutput("rst_txd", txd, 1);
        checkOutput("rst_tbre", tbre, 1);
        checkOutput("rst_tsre", tsre, 1);
        checkOutput("rst_data_ready", data_ready, 0);
        doRead(8'h00);
        repeat (4) @(posedge CLK);

        // Test 1: single write of 0xA5 with frame timing
        fork
            doWrite(8'hA5, 1'b1);
            begin
                n = 0;
                while (tbre !== 1'b0 && n < 30) begin @(negedge CLK); n++; end
                checkOutput("t1_tbre_fall", tbre, 0);
                n = 0;
                while (txd !== 1'b0 && n < 30) begin @(negedge CLK); n++; end
                checkOutput("t1_start_bit", txd, 0);
                checkOutput("t1_tbre_rise", tbre, 1);
                checkOutput("t1_tsre_busy", tsre, 0);
                n = 0;
                while (tsre !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
                checkOutput("t1_frame_cycles", n, 40);
            end
        join
        repeat (4) @(posedge CLK);

        // Tests 2 and 3: back-to-back writes, third write dropped
        fork
            begin
                doWrite(8'h11, 1'b1);
                doWrite(8'h22, 1'b1);
                @(negedge CLK);
                checkOutput("t2_tbre_busy", tbre, 0);
                doWrite(8'h33, 1'b0);
            end
            begin
                n = 0;
                while (txd !== 1'b0 && n < 30) begin @(negedge CLK); n++; end
                n = 0;
                while (tsre !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
                checkOutput("t2_two_frames_cycles", n, 80);
            end
        join
        repeat (8) @(posedge CLK);
        checkOutput("t3_tx_queue_empty", tx_exp.size(), 0);
        checkOutput("t3_line_idle", txd, 1);

        // Test 4: receive 0x3C and read it back
        sendRxFrame(8'h3C, 1'b1);
        @(negedge CLK);
        checkOutput("t4_data_ready", data_ready, 1);
        doRead(8'h3C);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        checkOutput("t4_data_ready_clear", data_ready, 0);

        // Test 5: glitch and framing error leave RBR alone
        @(posedge CLK);
        #1 rxd = 1'b0;
        @(posedge CLK);
        #1 rxd = 1'b1;
        repeat (4 * CPB) @(posedge CLK);
        @(negedge CLK);
        checkOutput("t5_glitch_no_load", data_ready, 0);
        sendRxFrame(8'h99, 1'b0);
        @(negedge CLK);
        checkOutput("t5_framing_no_load", data_ready, 0);
        doRead(8'h3C);
        repeat (4) @(posedge CLK);

        // Overrun: second byte overwrites, data_ready stays set
        sendRxFrame(8'h12, 1'b1);
        sendRxFrame(8'h34, 1'b1);
        @(negedge CLK);
        checkOutput("ovr_data_ready", data_ready, 1);
        doRead(8'h34);
        repeat (4) @(posedge CLK);

        // Test 6: reset in the middle of a frame
        doWrite(8'hC3, 1'b0);
        doWrite(8'h7E, 1'b0);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        checkOutput("t6_pre_tbre", tbre, 0);
        checkOutput("t6_pre_txd", txd, 0);
        #1 RST = 1'b0;
        #1;
        checkOutput("t6_txd", txd, 1);
        checkOutput("t6_tbre", tbre, 1);
        checkOutput("t6_tsre", tsre, 1);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (4) @(posedge CLK);
        checkOutput("t6_no_frame", txd, 1);
        doWrite(8'h5A, 1'b1);

        n = 0;
        while ((tsre !== 1'b1 || tx_exp.size() != 0) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(posedge CLK);
        checkOutput("end_tx_queue_empty", tx_exp.size(), 0);
        checkOutput("end_rd_queue_empty", rd_exp.size(), 0);
    endtask

    // Transmit monitor: decodes every frame on txd, checks each bit is
    // held for CPB cycles, and compares the byte with the scoreboard.
    initial begin : tx_monitor
        logic [9:0] bits;
        logic [7:0] exp_byte;
        bit shape_ok;
        bit aborted;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1 && txd === 1'b0) begin
                shape_ok = 1'b1;
                aborted  = 1'b0;
                bits     = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge CLK);
                        if (RST !== 1'b1) aborted = 1'b1;
                        else if (c == 0) bits[b] = txd;
                        else if (txd !== bits[b]) shape_ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    checks++;
                    if (!shape_ok || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL tx_frame actual=%b required start=0 stop=1 steady=1 (steady=%0d)",
                                 bits, shape_ok);
                    end
                    if (tx_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL tx_unexpected actual=%0h required=no frame", bits[8:1]);
                    end else begin
                        exp_byte = tx_exp.pop_front();
                        checkOutput("tx_byte", {24'h0, bits[8:1]}, {24'h0, exp_byte});
                    end
                end
            end
        end
    end

    // Read monitor: samples the bus on the second cycle of each read.
    initial begin : rd_monitor
        int low_cnt;
        logic [7:0] exp_byte;
        low_cnt = 0;
        forever begin
            @(negedge CLK);
            if (rdn === 1'b0) begin
                low_cnt++;
                if (low_cnt == 2) begin
                    if (rd_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL rd_unexpected actual=%0h required=no read", data);
                    end else begin
                        exp_byte = rd_exp.pop_front();
                        checkOutput("rd_byte", {24'h0, data}, {24'h0, exp_byte});
                    end
                end
            end else begin
                low_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
